// File: rtl/systolic_pkg.sv
// systolic_pkg -- shared definitions for the systolic array controller.
//   state_t     : controller FSM state encoding (3 bits)
//   DEF_*       : default array dimension, operand width and reduction length
//   FLUSH_LEN   : wavefront drain length (2N-1) for the default array size
//   flush_len() : drain length for an arbitrary array dimension
package systolic_pkg;

    localparam int unsigned DEF_N      = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_K_MAX  = 16;

    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    localparam int unsigned FLUSH_LEN = flush_len(DEF_N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_skew.sv
// systolic_skew -- per-lane skew delay line with valid tracking.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_data carries a real operand this cycle
//   in_data    : operand from the buffer read port (DATA_W bits)
//   out_data   : in_data delayed DEPTH cycles, forced to 0 when its valid is low
// DEPTH = 0 is a purely combinational gate.
module systolic_skew #(
    parameter int unsigned DEPTH  = 0,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data
);

    if (DEPTH == 0) begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_data = in_valid ? in_data : '0;
    end else begin : g_pipe
        logic [DATA_W-1:0] data_q [DEPTH];
        logic [DEPTH-1:0]  vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int unsigned s = 0; s < DEPTH; s++) begin
                    data_q[s] <= '0;
                end
            end else begin
                vld_q[0]  <= in_valid;
                data_q[0] <= in_data;
                for (int unsigned s = 1; s < DEPTH; s++) begin
                    vld_q[s]  <= vld_q[s-1];
                    data_q[s] <= data_q[s-1];
                end
            end
        end

        assign out_data = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
    end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl -- sequencing controller for the NxN PE_core systolic array.
// Clears accumulators, streams k_len operand columns with per-lane skew into
// the array edges, waits for the wavefront to drain, then hands off the result.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, k_len            : job request and reduction length (sampled in IDLE)
//   busy                    : controller not in IDLE
//   acc_clr                 : accumulator clear to all PEs
//   a/b_rd_en, a/b_rd_addr  : operand buffer read strobe and column index
//   a/b_rd_data             : buffer read data, 1-cycle latency, N lanes
//   a_feed, b_feed          : skewed operands into row/column edges of the array
//   res_valid, res_ready    : result handshake; done = res_valid & res_ready
//   perf_cycles, perf_stall : only with SYS_CTRL_PERF_EN defined
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned K_MAX  = DEF_K_MAX,
    parameter int unsigned K_W    = $clog2(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                acc_clr,
    output logic                a_rd_en,
    output logic                b_rd_en,
    output logic [K_W-1:0]      a_rd_addr,
    output logic [K_W-1:0]      b_rd_addr,
    input  logic [N*DATA_W-1:0] a_rd_data,
    input  logic [N*DATA_W-1:0] b_rd_data,
    output logic [N*DATA_W-1:0] a_feed,
    output logic [N*DATA_W-1:0] b_feed,
    output logic                res_valid,
    input  logic                res_ready,
`ifdef SYS_CTRL_PERF_EN
    output logic [31:0]         perf_cycles,
    output logic [15:0]         perf_stall,
`endif
    output logic                done
);

    localparam int unsigned FLUSH_CYC = (N == DEF_N) ? FLUSH_LEN : flush_len(N);
    localparam int unsigned PH_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t          state, state_nx;
    logic [K_W-1:0]  k_lat;
    logic [K_W-1:0]  addr_cnt;
    logic [PH_W-1:0] ph_cnt;
    logic            rd_vld;
    logic            accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k_lat    <= '0;
            addr_cnt <= '0;
            ph_cnt   <= '0;
            rd_vld   <= 1'b0;
        end else begin
            state    <= state_nx;
            // Buffer has one cycle of read latency; valid follows the strobe.
            rd_vld   <= a_rd_en;
            if (accept) begin
                k_lat <= (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;
            end
            addr_cnt <= (state == FEED)  ? addr_cnt + 1'b1 : '0;
            ph_cnt   <= (state == FLUSH) ? ph_cnt + 1'b1   : '0;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        busy      = 1'b0;
        acc_clr   = 1'b0;
        a_rd_en   = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                acc_clr  = 1'b1;
                state_nx = (k_lat == '0) ? DONE : FEED;
            end
            FEED: begin
                busy    = 1'b1;
                a_rd_en = 1'b1;
                if (addr_cnt == k_lat - 1'b1) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (ph_cnt == PH_W'(FLUSH_CYC - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign b_rd_en   = a_rd_en;
    assign a_rd_addr = a_rd_en ? addr_cnt : '0;
    assign b_rd_addr = a_rd_addr;

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_skew #(.DEPTH(i), .DATA_W(DATA_W)) u_skew_a (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (rd_vld),
            .in_data  (a_rd_data[i*DATA_W +: DATA_W]),
            .out_data (a_feed[i*DATA_W +: DATA_W])
        );
        systolic_skew #(.DEPTH(i), .DATA_W(DATA_W)) u_skew_b (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (rd_vld),
            .in_data  (b_rd_data[i*DATA_W +: DATA_W]),
            .out_data (b_feed[i*DATA_W +: DATA_W])
        );
    end

`ifdef SYS_CTRL_PERF_EN
    // perf_cycles starts at 1 on the accepting edge so it equals the
    // res_valid rise cycle number; it then freezes until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (accept) begin
            perf_cycles <= 32'd1;
            perf_stall  <= '0;
        end else begin
            if (state == CLEAR || state == FEED || state == FLUSH) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (state == DONE && !res_ready && perf_stall != '1) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int K_MAX  = 16;
    localparam int K_W    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                res_ready = 1'b0;
    logic [K_W-1:0]      k_len = '0;
    logic                busy, acc_clr, a_rd_en, b_rd_en, res_valid, done;
    logic [K_W-1:0]      a_rd_addr, b_rd_addr;
    logic [N*DATA_W-1:0] a_rd_data = '0, b_rd_data = '0;
    logic [N*DATA_W-1:0] a_feed, b_feed;
`ifdef SYS_CTRL_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_stall;
`endif

    systolic_ctrl #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX), .K_W(K_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .acc_clr   (acc_clr),
        .a_rd_en   (a_rd_en),
        .b_rd_en   (b_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_addr (b_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_data (b_rd_data),
        .a_feed    (a_feed),
        .b_feed    (b_feed),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef SYS_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall),
`endif
        .done      (done)
    );

    // Operand buffers: column k, lane i; 1-cycle registered read.
    logic [DATA_W-1:0] mem_a [K_MAX][N];
    logic [DATA_W-1:0] mem_b [K_MAX][N];

    always @(posedge clk) begin
        if (a_rd_en)
            for (int i = 0; i < N; i++) a_rd_data[i*DATA_W +: DATA_W] <= mem_a[a_rd_addr][i];
        if (b_rd_en)
            for (int i = 0; i < N; i++) b_rd_data[i*DATA_W +: DATA_W] <= mem_b[b_rd_addr][i];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    // Job model: m_rel is the cycle number relative to the accepting edge.
    bit m_active = 1'b0;
    int m_rel    = 0;
    int m_k      = 0;

    function automatic int rv_of(input int k);
        return (k == 0) ? 2 : k + 2 * N + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_rel    = 0;
        end else if (m_active) begin
            if (m_rel >= rv_of(m_k) && res_ready) m_active = 1'b0;
            else m_rel++;
        end else if (start) begin
            m_active = 1'b1;
            m_rel    = 1;
            m_k      = (int'(k_len) > K_MAX) ? K_MAX : int'(k_len);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observation log for literal per-job expectations.
    int t0, clr_cnt, clr_cyc, rd_cnt, rd_first, vld_first, vld_cnt;
    int done_cnt, done_cyc, l3_cnt, l3_first, nz_cnt;
    logic [DATA_W-1:0] l3_val;
    int addr_q[$];

    task automatic clear_log();
        clr_cnt = 0; clr_cyc = -1; rd_cnt = 0; rd_first = -1; vld_first = -1;
        vld_cnt = 0; done_cnt = 0; done_cyc = -1; l3_cnt = 0; l3_first = -1;
        nz_cnt = 0; l3_val = '0; addr_q.delete();
    endtask

    always @(negedge clk) begin
        int rv, col, rel;
        bit erd, evld;
        logic [N*DATA_W-1:0] ea, eb;
        rv   = rv_of(m_k);
        erd  = m_active && m_rel >= 2 && m_rel <= m_k + 1;
        evld = m_active && m_rel >= rv;
        ea = '0;
        eb = '0;
        if (m_active) begin
            for (int i = 0; i < N; i++) begin
                col = m_rel - 3 - i;
                if (col >= 0 && col < m_k) begin
                    ea[i*DATA_W +: DATA_W] = mem_a[col][i];
                    eb[i*DATA_W +: DATA_W] = mem_b[col][i];
                end
            end
        end
        chk("busy", busy, m_active);
        chk("acc_clr", acc_clr, m_active && m_rel == 1);
        chk("a_rd_en", a_rd_en, erd);
        chk("b_rd_en", b_rd_en, erd);
        if (erd) begin
            chk("a_rd_addr", a_rd_addr, m_rel - 2);
            chk("b_rd_addr", b_rd_addr, m_rel - 2);
        end
        chk("res_valid", res_valid, evld);
        chk("done", done, evld && res_ready);
        chk("a_feed", a_feed, ea);
        chk("b_feed", b_feed, eb);

        rel = cyc - t0;
        if (acc_clr) begin clr_cnt++; clr_cyc = rel; end
        if (a_rd_en) begin
            if (rd_cnt == 0) rd_first = rel;
            rd_cnt++;
            addr_q.push_back(int'(a_rd_addr));
        end
        if (res_valid) begin
            if (vld_first < 0) vld_first = rel;
            vld_cnt++;
        end
        if (done) begin done_cnt++; done_cyc = rel; end
        if (a_feed[3*DATA_W +: DATA_W] != '0) begin
            if (l3_cnt == 0) l3_first = rel;
            l3_cnt++;
            l3_val = a_feed[3*DATA_W +: DATA_W];
        end
        if (a_feed != '0 || b_feed != '0) nz_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int k);
        clear_log();
        t0    = cyc;
        k_len = K_W'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic chk_addrs(input string name);
        for (int j = 0; j < addr_q.size(); j++)
            chk($sformatf("%s_addr%0d", name, j), addr_q[j], j);
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                if (mode == 0) begin
                    mem_a[k][i] = DATA_W'(i + 1);
                    mem_b[k][i] = DATA_W'(k + 1);
                end else begin
                    mem_a[k][i] = DATA_W'(k * 16 + i + 1);
                    mem_b[k][i] = DATA_W'(255 - k * 4 - i);
                end
            end
    endtask

    initial begin
        clear_log();
        t0 = 0;
        fill(0);
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_a_rd_addr", a_rd_addr, '0);
        chk("rst_a_feed", a_feed, '0);
        chk("rst_res_valid", res_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic job
        res_ready = 1'b1;
        launch(4);
        wait_idle("basic", 40);
        chk("basic_clr_cnt", clr_cnt, 1);
        chk("basic_clr_cyc", clr_cyc, 1);
        chk("basic_rd_cnt", rd_cnt, 4);
        chk("basic_rd_first", rd_first, 2);
        chk_addrs("basic");
        chk("basic_l3_first", l3_first, 6);
        chk("basic_l3_cnt", l3_cnt, 4);
        chk("basic_l3_val", l3_val, 4);
        chk("basic_vld_first", vld_first, 13);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_cyc", done_cyc, 13);

        // k_len = 0
        launch(0);
        wait_idle("k0", 20);
        chk("k0_rd_cnt", rd_cnt, 0);
        chk("k0_vld_first", vld_first, 2);
        chk("k0_done_cyc", done_cyc, 2);
        chk("k0_feed_nz", nz_cnt, 0);

        // Clamp
        fill(1);
        launch(20);
        wait_idle("clamp", 60);
        chk("clamp_rd_cnt", rd_cnt, 16);
        chk_addrs("clamp");
        chk("clamp_vld_first", vld_first, 25);
        chk("clamp_done_cyc", done_cyc, 25);

        // Backpressure: DONE from cycle 12, ready low for 12..16
        res_ready = 1'b0;
        launch(3);
        while ((cyc - t0) < 17) tick();
        res_ready = 1'b1;
        wait_idle("bp", 20);
        chk("bp_vld_first", vld_first, 12);
        chk("bp_vld_cnt", vld_cnt, 6);
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_done_cyc", done_cyc, 17);
`ifdef SYS_CTRL_PERF_EN
        chk("bp_perf_stall", perf_stall, 5);
        chk("bp_perf_cycles", perf_cycles, 12);
`endif

        // Start while busy, start coincident with done, then back-to-back start
        launch(4);
        tick();
        tick();
        start = 1'b1;
        k_len = K_W'(2);
        tick();
        start = 1'b0;
        while ((cyc - t0) < 13) tick();
        start = 1'b1;
        k_len = K_W'(1);
        tick();
        chk("sb_busy_after_done", busy, 1'b0);
        chk("sb_rd_cnt", rd_cnt, 4);
        chk_addrs("sb");
        chk("sb_done_cyc", done_cyc, 13);
        clear_log();
        t0 = cyc;
        tick();
        start = 1'b0;
        wait_idle("b2b", 30);
        chk("b2b_rd_cnt", rd_cnt, 1);
        chk("b2b_vld_first", vld_first, 10);
        chk("b2b_done_cyc", done_cyc, 10);

        // Mid-job asynchronous reset in FEED cycle 3
        launch(4);
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_acc_clr", acc_clr, 1'b0);
        chk("mr_a_rd_en", a_rd_en, 1'b0);
        chk("mr_a_feed", a_feed, '0);
        chk("mr_b_feed", b_feed, '0);
        chk("mr_res_valid", res_valid, 1'b0);
        chk("mr_done", done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_no_done", done_cnt, 0);
        launch(4);
        wait_idle("mr_fresh", 40);
        chk("mr_fresh_rd_cnt", rd_cnt, 4);
        chk_addrs("mr_fresh");
        chk("mr_fresh_vld_first", vld_first, 13);
        chk("mr_fresh_done_cnt", done_cnt, 1);
        chk("mr_fresh_done_cyc", done_cyc, 13);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
